dcpu_membus: RTL
================

Name: dcpu_membus

Overview:
- Single-master bus controller sitting directly downstream of the dcpu core's memory port (addr/dat/we/cs/ack).
- Decodes each CPU request into one of three targets:
  - on-chip synchronous RAM,
  - an 8-bit-addressed I/O peripheral strobe bus,
  - an unmapped hole.
- Generates the single-cycle o_ack the core waits on in FETCH and in memory-accessing EXECUTE.

Parameters:
- W, 16, data/address width.
- RAM_WAIT, 1, cycles o_ram_ce is held before read data is sampled; range 1..15.
- IO_TIMEOUT, 255, max cycles to wait for i_io_ack; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_addr  in  W  CPU address.
- i_dat  in  W  CPU write data.
- o_dat  out  W  read data to CPU; valid while o_ack=1.
- i_we  in  1  CPU write enable.
- i_cs  in  1  CPU request; held high until o_ack.
- o_ack  out  1  one-cycle completion pulse.
- o_ram_addr  out  W-4  RAM word address (i_addr[11:0] for W=16).
- o_ram_dat  out  W  RAM write data.
- i_ram_dat  in  W  RAM read data.
- o_ram_we  out  1  RAM write strobe.
- o_ram_ce  out  1  RAM chip enable.
- o_io_addr  out  8  I/O register index.
- o_io_dat  out  W  I/O write data.
- i_io_dat  in  W  I/O read data.
- o_io_we  out  1  I/O write qualifier.
- o_io_stb  out  1  I/O strobe; held until i_io_ack.
- i_io_ack  in  1  I/O completion.

Behaviour:
- Reset: i_reset, synchronous, active-high; clock i_clk.
- Reset values:
  - state=IDLE.
  - o_ack=0, o_dat=0.
  - o_ram_ce=0, o_ram_we=0, o_io_stb=0, o_io_we=0.
  - Latched address/data registers = 0.
- Reset mid-access aborts immediately: all strobes drop the next edge and no ack is issued.
- Address map (W=16):
  - 0x0000-0x0FFF: RAM.
  - 0xFF00-0xFFFF: I/O; o_io_addr=addr[7:0].
  - Everything else: UNMAPPED.
- FSM states: IDLE, RAM, IO, DONE.
- IDLE:
  - When i_cs=1, latch addr, dat and we into registers.
  - Decode the latched address and move to RAM (cnt<=RAM_WAIT-1), IO, or DONE (unmapped).
  - All downstream outputs are driven from the latched copies only, never directly from CPU inputs.
- RAM:
  - o_ram_ce=1 every cycle in this state; o_ram_we=latched we.
  - Each cycle with cnt!=0: cnt decrements.
  - cnt==0 cycle:
    - o_dat<=i_ram_dat on reads; o_dat<=0 on writes.
    - o_ack<=1, go DONE.
- IO:
  - o_io_stb=1 and o_io_we=latched we every cycle in this state.
  - On i_io_ack=1: o_dat<=i_io_dat (reads) or 0 (writes), o_ack<=1, go DONE.
  - i_io_ack outside IO is ignored.
- DONE:
  - o_ack=1 for exactly this one cycle, then IDLE.
  - o_ack is cleared the next edge regardless of i_cs.
- Unmapped access: IDLE->DONE with o_dat=0; writes are discarded.
- Latency, i_cs rising to o_ack high:
  - RAM: RAM_WAIT+1 cycles.
  - Unmapped: 1 cycle.
  - IO: 1 + cycles to i_io_ack.
- Back-to-back: i_cs held high through DONE is sampled again in IDLE on the next cycle. This is a new request (the CPU advances state on ack). Minimum spacing is one IDLE cycle between acks.
- Without the optional feature, IO waits indefinitely for i_io_ack.
- i_cs dropping mid-access is a protocol violation: the access completes and the ack is still pulsed.

Optional Feature:
- Macro: DCPU_MEMBUS_TIMEOUT_EN.
- With the macro defined:
  - Adds output o_buserr (1 bit, reset 0) and an 8-bit timeout counter, cleared on entry to IO.
  - If IO_TIMEOUT cycles elapse without i_io_ack: o_dat<=16'hDEAD, o_ack<=1, o_buserr<=1, go DONE.
  - Unmapped accesses also set o_buserr=1.
  - o_buserr is sticky until reset.
- Without the macro: no o_buserr port, no counter; behaviour exactly as in Behaviour.

Decomposition:
- Package dcpu_bus_pkg holds:
  - state enum {IDLE, RAM, IO, DONE};
  - region constants RAM_BASE=16'h0000, RAM_LAST=16'h0FFF, IO_BASE=16'hFF00;
  - target enum {T_RAM, T_IO, T_NONE}.
- One natural sub-module: dcpu_membus_decode, a purely combinational mapping from addr to target; reused later by the DMA master.
- FSM and counters stay in dcpu_membus.

Test Plan:
- Reset, then read from RAM: preload RAM[0x0010]=0x1234; i_cs=1, i_addr=0x0010, i_we=0 → o_ram_ce high for 1 cycle, o_ack pulse 2 cycles after i_cs, o_dat=0x1234.
- RAM_WAIT=3 write: addr 0x0FFF, dat 0xBEEF → o_ram_we=o_ram_ce=1 for 3 cycles, o_ack at cycle 4; a subsequent read of 0x0FFF returns 0xBEEF.
- I/O read: addr 0xFF05; peripheral acks 4 cycles after o_io_stb with i_io_dat=0x00A5 → o_io_addr=0x05, o_dat=0x00A5, o_ack exactly one cycle, o_io_stb low the next cycle.
- Back-to-back fetch/execute: i_cs held high across two RAM reads (0x0001, then 0x0002) → two distinct ack pulses separated by one IDLE cycle, correct data each time.
- Unmapped read at 0x8000 → ack 1 cycle after i_cs, o_dat=0; with DCPU_MEMBUS_TIMEOUT_EN, o_buserr=1.
- Reset mid-access: i_reset asserted during an IO wait → o_io_stb=0 and o_ack=0 the next cycle, state IDLE. With DCPU_MEMBUS_TIMEOUT_EN and IO_TIMEOUT=8 and no peripheral ack: o_dat=0xDEAD and o_buserr=1 after 8 cycles.

Source files
------------

// File: rtl/dcpu_membus_pkg.sv
// rtl/dcpu_membus_pkg.sv - shared bus states, targets and region constants for the dcpu memory bus
package dcpu_bus_pkg;

    typedef enum logic [1:0] {IDLE, RAM, IO, DONE} state_t;
    typedef enum logic [1:0] {T_RAM, T_IO, T_NONE} target_t;

    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] RAM_LAST = 16'h0FFF;
    localparam logic [15:0] IO_BASE  = 16'hFF00;

endpackage

// File: rtl/dcpu_membus_decode.sv
// rtl/dcpu_membus_decode.sv - combinational address-to-target decode, shared with the DMA master
module dcpu_membus_decode
    import dcpu_bus_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] addr,
    output target_t      target
);

    always_comb begin
        target = T_NONE;
        if ((addr & ~W'(RAM_LAST)) == W'(RAM_BASE)) begin
            target = T_RAM;
        end else if ((addr & W'(IO_BASE)) == W'(IO_BASE)) begin
            target = T_IO;
        end
    end

endmodule

// File: rtl/dcpu_membus.sv
// rtl/dcpu_membus.sv - dcpu memory port controller: RAM / I/O strobe bus / unmapped, single-cycle ack
// Optional I/O timeout and o_buserr reporting under DCPU_MEMBUS_TIMEOUT_EN.
module dcpu_membus
    import dcpu_bus_pkg::*;
#(
    parameter int W          = 16,
    parameter int RAM_WAIT   = 1,
    parameter int IO_TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_addr,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat,
    input  logic         i_we,
    input  logic         i_cs,
    output logic         o_ack,
`ifdef DCPU_MEMBUS_TIMEOUT_EN
    output logic         o_buserr,
`endif
    output logic [W-5:0] o_ram_addr,
    output logic [W-1:0] o_ram_dat,
    input  logic [W-1:0] i_ram_dat,
    output logic         o_ram_we,
    output logic         o_ram_ce,
    output logic [7:0]   o_io_addr,
    output logic [W-1:0] o_io_dat,
    input  logic [W-1:0] i_io_dat,
    output logic         o_io_we,
    output logic         o_io_stb,
    input  logic         i_io_ack
);

    if (RAM_WAIT < 1 || RAM_WAIT > 15 || IO_TIMEOUT < 1 || IO_TIMEOUT > 255) begin : g_param_check
        $error("dcpu_membus: RAM_WAIT or IO_TIMEOUT out of range");
    end

    state_t        state_q, state_d;
    target_t       target;
    logic [W-5:0]  addr_q;
    logic [W-1:0]  dat_q;
    logic          we_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [W-1:0]  dat_d;
    logic          ack_d;
    logic          latch;
`ifdef DCPU_MEMBUS_TIMEOUT_EN
    logic [7:0]    tmo_q, tmo_d;
    logic          buserr_d;
`endif

    // Decoding i_addr on the latch edge sees exactly the value being captured into addr_q.
    dcpu_membus_decode #(.W(W)) u_decode (
        .addr   (i_addr),
        .target (target)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dat_d    = o_dat;
        ack_d    = 1'b0;
        latch    = 1'b0;
`ifdef DCPU_MEMBUS_TIMEOUT_EN
        tmo_d    = tmo_q;
        buserr_d = o_buserr;
`endif
        case (state_q)
            IDLE: begin
                if (i_cs) begin
                    latch = 1'b1;
                    case (target)
                        T_RAM: begin
                            state_d = RAM;
                            cnt_d   = 4'(RAM_WAIT - 1);
                        end
                        T_IO: begin
                            state_d = IO;
`ifdef DCPU_MEMBUS_TIMEOUT_EN
                            tmo_d   = '0;
`endif
                        end
                        default: begin
                            state_d  = DONE;
                            dat_d    = '0;
                            ack_d    = 1'b1;
`ifdef DCPU_MEMBUS_TIMEOUT_EN
                            buserr_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
            RAM: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    dat_d   = we_q ? '0 : i_ram_dat;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            IO: begin
                if (i_io_ack) begin
                    dat_d   = we_q ? '0 : i_io_dat;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
`ifdef DCPU_MEMBUS_TIMEOUT_EN
                else if (tmo_q == 8'(IO_TIMEOUT - 1)) begin
                    dat_d    = W'(16'hDEAD);
                    ack_d    = 1'b1;
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            o_dat    <= '0;
            o_ack    <= 1'b0;
`ifdef DCPU_MEMBUS_TIMEOUT_EN
            tmo_q    <= '0;
            o_buserr <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            o_dat    <= dat_d;
            o_ack    <= ack_d;
`ifdef DCPU_MEMBUS_TIMEOUT_EN
            tmo_q    <= tmo_d;
            o_buserr <= buserr_d;
`endif
            if (latch) begin
                addr_q <= i_addr[W-5:0];
                dat_q  <= i_dat;
                we_q   <= i_we;
            end
        end
    end

    assign o_ram_ce   = (state_q == RAM);
    assign o_ram_we   = o_ram_ce & we_q;
    assign o_ram_addr = addr_q;
    assign o_ram_dat  = dat_q;
    assign o_io_stb   = (state_q == IO);
    assign o_io_we    = o_io_stb & we_q;
    assign o_io_addr  = addr_q[7:0];
    assign o_io_dat   = dat_q;

endmodule
